// File: rtl/seq_mult_16bit.sv
// Sequential 16x16 unsigned shift-add multiplier built around a 16-bit
// carry-lookahead adder. One partial-product add-and-shift per clock;
// 32-bit product after 16 iterations. Start/busy/done handshake.

// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry unit.
// P/G are the whole-word propagate/generate terms for cascading.
module cla_16bit_LCU (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        P,
    output logic        G
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    // Bit/group propagate-generate, group carries, then in-group carries and sum.
    always_comb begin
        p = in1 ^ in2;
        g = in1 & in2;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        G     = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
        P     = &gp;
        gc[4] = G | (P & cin);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        sum  = p ^ c;
        cout = gc[4];
    end
endmodule

module seq_mult_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] a_q, a_d;
    logic [15:0] q_q, q_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;

    logic [15:0] addend;
    logic [15:0] add_sum;
    logic        add_cout;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign addend = q_q[0] ? m_q : 16'd0;

    cla_16bit_LCU u_cla (
        .in1  (a_q),
        .in2  (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout),
        .P    (),
        .G    ()
    );

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_q       <= 16'd0;
            a_q       <= 16'd0;
            q_q       <= 16'd0;
            cnt_q     <= 4'd0;
            product_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: accept in IDLE/DONE, one shift-add per RUN cycle.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = 16'd0;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // 17-bit {cout,sum} shifted right with Q keeps every carry.
                {a_d, q_d} = {add_cout, add_sum, q_q[15:1]};
                if (cnt_q == 4'd15) begin
                    state_d   = DONE;
                    product_d = {add_cout, add_sum, q_q[15:1]};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_seq_mult_16bit.sv
// Directed testbench for seq_mult_16bit: reset, latency/handshake,
// arithmetic corners, ignored restarts, back-to-back and mid-run reset.
module tb_seq_mult_16bit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int failures;

    seq_mult_16bit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        multiplicand = 16'd0;
        multiplier = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++;
        if (product !== 32'd0) begin failures++; $display("FAIL reset_product got=%h exp=00000000", product); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; leaves just after a rising edge, in IDLE.
    task automatic run_mult(input string name, input logic [15:0] m, input logic [15:0] q,
                            input logic [31:0] exp, input int re1, input int re2);
        logic [31:0] prev;
        int n;
        int busy_cnt;
        bit seen;
        bit held;
        multiplicand = m;
        multiplier = q;
        start = 1'b1;
        prev = product;
        n = 0;
        busy_cnt = 0;
        seen = 0;
        held = 1;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == re1) || (n == re2);
            multiplicand = 16'hDEAD;
            multiplier = 16'hBEEF;
            if (busy) busy_cnt++;
            if (done) seen = 1;
            else if (product !== prev) held = 0;
        end
        start = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL %s_timeout no done within %0d edges", name, n); end
        checks++;
        if (n != 17) begin failures++; $display("FAIL %s_latency got=%0d exp=17", name, n); end
        checks++;
        if (busy_cnt != 16) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=16", name, busy_cnt); end
        checks++;
        if (product !== exp) begin failures++; $display("FAIL %s_product got=%h exp=%h", name, product, exp); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%0b exp=0", name, busy); end
        checks++;
        if (!held) begin failures++; $display("FAIL %s_product_hold got=changed exp=held %h", name, prev); end
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_after_done got done=%0b busy=%0b exp=0/0", name, done, busy);
            end
        end
    endtask

    task automatic test_basic();
        run_mult("3x5", 16'd3, 16'd5, 32'h0000000F, 0, 0);
        run_mult("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 0);
    endtask

    task automatic test_zero();
        run_mult("0xabcd", 16'h0000, 16'hABCD, 32'd0, 0, 0);
        run_mult("1234x0", 16'h1234, 16'h0000, 32'd0, 0, 0);
    endtask

    task automatic test_ignore_start();
        run_mult("restart_ignored", 16'h00FF, 16'h0100, 32'h0000FF00, 3, 10);
    endtask

    task automatic test_back_to_back();
        int n;
        int k;
        multiplicand = 16'h8000;
        multiplier = 16'h0002;
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
        end
        checks++;
        if (n != 17) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=17", n); end
        checks++;
        if (product !== 32'h00010000) begin failures++; $display("FAIL b2b_first_product got=%h exp=00010000", product); end
        multiplicand = 16'h1234;
        multiplier = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_idle got busy=%0b done=%0b exp=1/0", busy, done);
        end
        checks++;
        if (product !== 32'h00010000) begin failures++; $display("FAIL b2b_hold got=%h exp=00010000", product); end
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != 17) begin failures++; $display("FAIL b2b_spacing got=%0d exp=17", k); end
        checks++;
        if (product !== 32'h06260060) begin failures++; $display("FAIL b2b_second_product got=%h exp=06260060", product); end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got done=%0b busy=%0b exp=0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        multiplicand = 16'hFFFF;
        multiplier = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", done); end
        checks++;
        if (product !== 32'd0) begin failures++; $display("FAIL midrst_product got=%h exp=00000000", product); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midrst_quiet got=%0d active cycles exp=0", bad); end
        run_mult("7x9", 16'd7, 16'd9, 32'h0000003F, 0, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mult_16bit.md
# seq_mult_16bit

Sequential 16x16 unsigned shift-add multiplier that uses the 16-bit carry-lookahead adder as its only arithmetic element. It sits downstream of the adder: it feeds the partial-product accumulator and multiplicand into a combinational `cla_16bit_LCU` instance each cycle, and consumes its `sum`/`cout` to build a 32-bit product over 16 iterations. A start/busy/done handshake lets an upstream controller issue one multiply at a time.

## Interface
- No parameters. Width is fixed at 16x16 -> 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; the block is held in reset while `rst`=0.
- `start`  in  1  request; sampled on a rising edge only when the FSM is in IDLE or DONE.
- `multiplicand`  in  16  operand M, unsigned; latched on the accepting edge.
- `multiplier`  in  16  operand Q, unsigned; latched on the accepting edge.
- `busy`  out  1  high while iterations are in progress (RUN state).
- `done`  out  1  one-cycle pulse; product is valid when this pulse is seen.
- `product`  out  32  registered result, held until the next completion.

## Operation
- Internal registers: `M_reg`[15:0], accumulator `A`[15:0], `Q_reg`[15:0], iteration counter `cnt`[3:0], FSM state.
- FSM states and transitions:
  - IDLE: `start`=1 -> RUN. Latch `M_reg`=multiplicand, `Q_reg`=multiplier, `A`=0, `cnt`=0.
  - RUN: perform one iteration per edge. When `cnt`=15 and the iteration completes -> DONE. Otherwise `cnt`++.
  - DONE: `done`=1 for this one state. `start`=1 -> RUN, with the same latching as from IDLE. Otherwise -> IDLE.
- Iteration in RUN:
  - Drive the adder with `in1`=`A`, `in2`=(`Q_reg`[0] ? `M_reg` : 16'd0), `cin`=0.
  - On the edge, shift right by one: {`A`,`Q_reg`} <= {`cout`, `sum`[15:0], `Q_reg`[15:1]}.
  - The adder's `P`/`G` outputs are unused.
- On the final iteration edge, `product` is loaded with {new `A`, new `Q_reg`}.
- `product` changes only on that edge or on reset.
- Arithmetic: 17-bit intermediate {`cout`,`sum`}, and no bit is lost.
- Result equals M*Q exactly, modulo nothing: the maximum 0xFFFF*0xFFFF = 0xFFFE0001 fits in 32 bits.
- `start` while in RUN is ignored. Operands are not re-sampled and the run is not restarted.
- Operand inputs are don't-care except on the accepting edge.
- `busy` = (state==RUN); `done` = (state==DONE). Both are decoded from registered state, so they are glitch-free.

## Timing
- Reset (`rst`=0, asynchronous, immediate):
  - state=IDLE; `busy`=0, `done`=0, `product`=0.
  - `A`, `Q_reg`, `M_reg`, `cnt` = 0.
  - Reset has priority over everything.
- Deassertion of `rst` takes effect at the next rising edge after it is observed high.
- Latency: call the edge that accepts `start` E0.
  - `busy` rises after E0.
  - Iterations occur on E1..E16.
  - After E16: `busy`=0, `done`=1, `product` valid.
  - After E17: `done`=0.
  - `start` to `done` is 17 edges.
- Throughput: back-to-back operation is supported. `start`=1 during the DONE cycle is accepted at E17, and `busy` is high again after E17. Spacing is 17 cycles per multiply with no idle gap.
- Reset mid-run: the run is aborted with no `done` pulse, and `product` returns to 0. After `rst` deasserts, the block is in IDLE and ready for a new `start`.
- `product` holds its previous value throughout a subsequent RUN. It updates only together with the next `done`.
- Adder path: the combinational depth per cycle is one 16-bit CLA plus a 16-bit mux. There is no multicycle path.

## Test plan
- Reset, then `start` with 3 x 5 -> `busy` high for 16 cycles; `done` pulses once, 17 edges after start; `product`=0x0000000F.
- 0xFFFF x 0xFFFF -> `product`=0xFFFE0001. This exercises `cout`=1 on most iterations.
- 0x0000 x 0xABCD and 0x1234 x 0x0000 -> `product`=0 for both. `done` timing is identical (still 16 iterations).
- `start` re-asserted on cycles 3 and 10 of a 0x00FF x 0x0100 run -> ignored; single `done`; `product`=0x0000FF00.
- Back-to-back: 0x8000 x 0x0002, with `start` held in the DONE cycle to launch 0x1234 x 0x5678 -> `product`=0x00010000, then 0x06260060 exactly 17 cycles later. There is no IDLE cycle between the two runs.
- `rst` pulled low at iteration 8 of 0xFFFF x 0xFFFF -> `busy`, `done` and `product` go to 0 asynchronously; no `done` follows. After release, `start` with 7 x 9 -> `product`=0x0000003F.
